// File: rtl/gate_pkg.sv
// -----------------------------------------------------------------------------
// gate_pkg
// Shared constants and helpers for the AND-gate input conditioning path.
//   DEF_SYNC_STAGES     - default synchroniser depth per channel
//   DEF_DEBOUNCE_CYCLES - default number of cycles a new level must persist
//   cnt_width(n)        - width of a counter that must hold values 0..n
// -----------------------------------------------------------------------------
package gate_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : gate_pkg

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One conditioning channel: a synchroniser chain followed by a stability
// counter and the registered debounced output.
// Ports:
//   clk    in  1  clock, all state on rising edge
//   rst_n  in  1  asynchronous active-low reset
//   en     in  1  1 = counter/output advance, 0 = counter/output hold
//   raw    in  1  raw asynchronous input
//   out    out 1  debounced level (flop)
//   upd    out 1  high when out takes a new value on the coming edge
// -----------------------------------------------------------------------------
module debounce_ch
    import gate_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic out,
    output logic upd
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;

    // The synchroniser keeps running while en is low so that the sampled
    // level is already current when debouncing resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Decision for the coming edge; only flop outputs leave the top level,
    // this term feeds the registered change strobe there.
    assign upd = en && (s != out) && (cnt == CNT_LAST);

    // Any return of s to the current output level restarts the count, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches out. With
    // DEBOUNCE_CYCLES == 1 CNT_LAST is 0 and out follows s one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (en) begin
            if (s == out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                out <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : debounce_ch

// File: rtl/and_input_debouncer.sv
// -----------------------------------------------------------------------------
// and_input_debouncer
// Conditions the two raw inputs of the AND gate: each is synchronised and
// debounced, and a single-cycle strobe marks every change of the clean pair.
// Ports:
//   clk    in  1  clock, all state on rising edge
//   rst_n  in  1  asynchronous active-low reset
//   en     in  1  1 = debouncing active, 0 = counters/outputs frozen
//   a_raw  in  1  raw input A (asynchronous)
//   b_raw  in  1  raw input B (asynchronous)
//   a_out  out 1  debounced A, registered
//   b_out  out 1  debounced B, registered
//   chg    out 1  one-cycle strobe, high in the cycle a_out/b_out change
//
// Handshake: chg is a valid-only strobe with no ready. In any cycle where chg
// is high, a_out/b_out already hold the new pair; the consumer must sample in
// that cycle. When both channels change on the same edge one pulse is issued.
// -----------------------------------------------------------------------------
module and_input_debouncer
    import gate_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_out,
    output logic b_out,
    output logic chg
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("and_input_debouncer: need SYNC_STAGES >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic upd_a;
    logic upd_b;

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .raw   (a_raw),
        .out   (a_out),
        .upd   (upd_a)
    );

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .raw   (b_raw),
        .out   (b_out),
        .upd   (upd_b)
    );

    // Registered alongside the output flops so the strobe and the new pair
    // appear in the same cycle. upd_* already include en, so a frozen block
    // never strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= 1'b0;
        end else begin
            chg <= upd_a | upd_b;
        end
    end

endmodule : and_input_debouncer

// File: tb/tb_and_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_and_input_debouncer
// Directed stimulus for the AND-gate input debouncer. Each expected output
// change is queued as {cycle, a_out, b_out, gate}; a monitor pops an entry on
// every chg strobe and otherwise checks that the outputs hold.
// -----------------------------------------------------------------------------
module tb_and_input_debouncer;

    localparam int EXP_W = 19;
    localparam int LAT   = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic a_raw;
    logic b_raw;
    logic a_out;
    logic b_out;
    logic chg;
    logic gate_y;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    and_input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a_out (a_out),
        .b_out (b_out),
        .chg   (chg)
    );

    // Downstream two-input AND gate fed by the conditioned pair.
    assign gate_y = a_out & b_out;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic mdl_a = 1'b0;
    logic mdl_b = 1'b0;
    logic last_a;
    logic last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int lat, input logic a, input logic b);
        exp_q.push_back({16'(cyc + lat), a, b, a & b});
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst_n) begin
            mdl_a = 1'b0;
            mdl_b = 1'b0;
        end else if (chg) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_chg: got a_out=%0b b_out=%0b expected no strobe (cycle %0d)",
                         a_out, b_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("chg_event", {13'd0, 16'(cyc), a_out, b_out, gate_y}, {13'd0, e});
                mdl_a = e[2];
                mdl_b = e[1];
            end
        end else begin
            check("hold_outs", {30'd0, a_out, b_out}, {30'd0, mdl_a, mdl_b});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a settled raw pair; queue the output change if the pair differs.
    task automatic set_raw(input logic a, input logic b);
        if ({a, b} != {last_a, last_b}) push_exp(LAT, a, b);
        a_raw  = a;
        b_raw  = b;
        last_a = a;
        last_b = b;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic old_g;
        logic [1:0] vec;
        en     = 1'b1;
        a_raw  = 1'b1;
        b_raw  = 1'b1;
        rst_n  = 1'b1;
        last_a = 1'b1;
        last_b = 1'b1;

        // Reset with raw inputs high: outputs are 0 at once.
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_out", {31'd0, a_out}, 32'd0);
        check("rst_b_out", {31'd0, b_out}, 32'd0);
        check("rst_chg",   {31'd0, chg},   32'd0);
        wait_neg(3);
        check("rst_hold_outs", {29'd0, a_out, b_out, chg}, 32'd0);

        // Release: held-high inputs reappear on the 6th edge.
        push_exp(LAT, 1'b1, 1'b1);
        rst_n = 1'b1;
        wait_neg(12);

        // Return to (0,0), then clean steps on A only.
        set_raw(1'b0, 1'b0); wait_neg(12);
        set_raw(1'b1, 1'b0); wait_neg(12);
        set_raw(1'b0, 1'b0); wait_neg(12);

        // Bounce: 3 cycles high, 1 low, then steady high.
        a_raw = 1'b1; wait_neg(3);
        a_raw = 1'b0; wait_neg(1);
        set_raw(1'b1, 1'b0); wait_neg(12);
        set_raw(1'b0, 1'b0); wait_neg(12);

        // Simultaneous change on both inputs.
        set_raw(1'b1, 1'b1); wait_neg(12);
        set_raw(1'b0, 1'b0); wait_neg(12);

        // Enable freeze after 3 edges for 10 cycles; count resumes at 1.
        push_exp(16, 1'b1, 1'b0);
        a_raw  = 1'b1;
        last_a = 1'b1;
        wait_neg(3);
        en = 1'b0;
        wait_neg(10);
        en = 1'b1;
        wait_neg(12);
        set_raw(1'b0, 1'b0); wait_neg(12);

        // Truth-table sweep through the AND gate, 20 cycles per vector.
        for (int i = 0; i < 4; i++) begin
            vec   = 2'(i);
            old_g = last_a & last_b;
            set_raw(vec[1], vec[0]);
            wait_neg(5);
            check("sweep_gate_before", {31'd0, gate_y}, {31'd0, old_g});
            wait_neg(1);
            check("sweep_gate_after", {31'd0, gate_y}, {31'd0, vec[1] & vec[0]});
            wait_neg(14);
        end

        // Reset mid-count: A starts a falling count, reset discards it.
        a_raw = 1'b0;
        wait_neg(3);
        #2 rst_n = 1'b0;
        a_raw = 1'b1;
        #1;
        check("midrst_outs", {29'd0, a_out, b_out, chg}, 32'd0);
        wait_neg(2);
        push_exp(LAT, 1'b1, 1'b1);
        rst_n = 1'b1;
        wait_neg(12);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_and_input_debouncer
